// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: active-low hex patterns {DP,G..A}
// and the blank/idle levels for anodes and cathodes.
package seg7_scan_driver_pkg;

  localparam int NUM_DIGITS         = 4;
  localparam int SUBSLOTS_PER_DIGIT = 8;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low segments G..A; a blanked digit drives all segments off.
// Latency: combinational; no backpressure.
module seg7_hex_decoder
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF[6:0];
    if (!blank) begin
      case (value)
        4'h0: seg = SEG_HEX_0[6:0];
        4'h1: seg = SEG_HEX_1[6:0];
        4'h2: seg = SEG_HEX_2[6:0];
        4'h3: seg = SEG_HEX_3[6:0];
        4'h4: seg = SEG_HEX_4[6:0];
        4'h5: seg = SEG_HEX_5[6:0];
        4'h6: seg = SEG_HEX_6[6:0];
        4'h7: seg = SEG_HEX_7[6:0];
        4'h8: seg = SEG_HEX_8[6:0];
        4'h9: seg = SEG_HEX_9[6:0];
        4'hA: seg = SEG_HEX_A[6:0];
        4'hB: seg = SEG_HEX_B[6:0];
        4'hC: seg = SEG_HEX_C[6:0];
        4'hD: seg = SEG_HEX_D[6:0];
        4'hE: seg = SEG_HEX_E[6:0];
        default: seg = SEG_HEX_F[6:0];
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 4-digit driver with frame snapshot, leading-zero blanking and PWM.
// Latency: outputs registered one cycle after counter state; free-running, no backpressure.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SUBSLOT_CYCLES = 3125
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DIGIT0,
  input  logic [3:0] DIGIT1,
  input  logic [3:0] DIGIT2,
  input  logic [3:0] DIGIT3,
  input  logic [3:0] DP_MASK,
  input  logic       BLANK_EN,
  input  logic [2:0] BRIGHTNESS,
  output logic [3:0] SEG_SELECT,
  output logic [7:0] LED_OUT,
  output logic       FRAME_START
);

  localparam int SC_W = (SUBSLOT_CYCLES > 1) ? $clog2(SUBSLOT_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SUBSLOT_CYCLES - 1);
  localparam logic [2:0] SUB_LAST = 3'(SUBSLOTS_PER_DIGIT - 1);

  logic [SC_W-1:0]  sub_cnt;
  logic [2:0]       sub_idx;
  logic [1:0]       dig_idx;

  logic [3:0][3:0]  sh_digits;
  logic [3:0]       sh_dp;
  logic             sh_blank_en;
  logic [2:0]       sh_bright;

  logic             snap;
  logic [3:0][3:0]  nx_digits;
  logic [3:0]       nx_dp;
  logic             nx_blank_en;
  logic [2:0]       nx_bright;
  logic [3:0]       blank;
  logic             lit;
  logic [3:0]       anode_on;
  logic [6:0]       seg;

  assign snap = (sub_cnt == '0) && (sub_idx == 3'd0) && (dig_idx == 2'd0);

  // A capture on this edge must already be visible in the outputs registered on this edge.
  assign nx_digits   = snap ? {DIGIT3, DIGIT2, DIGIT1, DIGIT0} : sh_digits;
  assign nx_dp       = snap ? DP_MASK    : sh_dp;
  assign nx_blank_en = snap ? BLANK_EN   : sh_blank_en;
  assign nx_bright   = snap ? BRIGHTNESS : sh_bright;

  always_comb begin
    blank    = '0;
    blank[3] = nx_blank_en && (nx_digits[3] == 4'h0);
    blank[2] = blank[3] && (nx_digits[2] == 4'h0);
    blank[1] = blank[2] && (nx_digits[1] == 4'h0);
  end

  assign lit      = (sub_idx <= nx_bright);
  assign anode_on = ~(4'b0001 << dig_idx);

  seg7_hex_decoder u_decoder (
    .value (nx_digits[dig_idx]),
    .blank (blank[dig_idx]),
    .seg   (seg)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sub_cnt     <= '0;
      sub_idx     <= '0;
      dig_idx     <= '0;
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_blank_en <= 1'b0;
      sh_bright   <= '0;
      SEG_SELECT  <= ANODES_OFF;
      LED_OUT     <= SEG_OFF;
      FRAME_START <= 1'b0;
    end else begin
      if (sub_cnt == SC_LAST) begin
        sub_cnt <= '0;
        if (sub_idx == SUB_LAST) begin
          sub_idx <= '0;
          dig_idx <= dig_idx + 2'd1;
        end else begin
          sub_idx <= sub_idx + 3'd1;
        end
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end

      if (snap) begin
        sh_digits   <= nx_digits;
        sh_dp       <= nx_dp;
        sh_blank_en <= nx_blank_en;
        sh_bright   <= nx_bright;
      end

      FRAME_START <= snap;
      SEG_SELECT  <= lit ? anode_on : ANODES_OFF;
      LED_OUT     <= lit ? {~nx_dp[dig_idx], seg} : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SUBSLOT_CYCLES=2 (16-cycle slot, 64-cycle frame).
// Latency: outputs compared one cycle after the modelled edge via an expectation queue.
// Backpressure: none; the driver is free-running and the bench only observes.
module tb_seg7_scan_driver;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] led;
        logic       fs;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] DIGIT0 = '0, DIGIT1 = '0, DIGIT2 = '0, DIGIT3 = '0;
    logic [3:0] DP_MASK = '0;
    logic       BLANK_EN = 1'b0;
    logic [2:0] BRIGHTNESS = '0;
    logic [3:0] SEG_SELECT;
    logic [7:0] LED_OUT;
    logic       FRAME_START;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    seg7_scan_driver #(.SUBSLOT_CYCLES(2)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .DIGIT0      (DIGIT0),
        .DIGIT1      (DIGIT1),
        .DIGIT2      (DIGIT2),
        .DIGIT3      (DIGIT3),
        .DP_MASK     (DP_MASK),
        .BLANK_EN    (BLANK_EN),
        .BRIGHTNESS  (BRIGHTNESS),
        .SEG_SELECT  (SEG_SELECT),
        .LED_OUT     (LED_OUT),
        .FRAME_START (FRAME_START)
    );

    always #5 CLK = ~CLK;

    // Reference model: a frame is 64 cycles; position p selects digit p/16, sub-slot (p%16)/2.
    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int         pos = 0;
    logic [3:0] m_dig [4];
    logic [3:0] m_dp = '0;
    logic       m_ben = 1'b0;
    int         m_bri = 0;
    int         md, msub;
    logic       m_blank;
    logic [7:0] m_pat;
    exp_t       e_m;

    always @(posedge CLK) begin
        if (!RESET) begin
            pos = 0;
            for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
            m_dp = '0; m_ben = 1'b0; m_bri = 0;
            e_m = '{sel: 4'hF, led: 8'hFF, fs: 1'b0};
        end else begin
            if (pos == 0) begin
                m_dig[0] = DIGIT0; m_dig[1] = DIGIT1; m_dig[2] = DIGIT2; m_dig[3] = DIGIT3;
                m_dp = DP_MASK; m_ben = BLANK_EN; m_bri = int'(BRIGHTNESS);
            end
            md   = pos / 16;
            msub = (pos % 16) / 2;
            // Blanked when enabled, not the rightmost digit, and this digit and all to its left are zero.
            m_blank = m_ben && (md != 0);
            for (int k = md; k < 4; k++) if (m_dig[k] != 4'h0) m_blank = 1'b0;
            m_pat = m_blank ? 8'hFF : hex_tab[m_dig[md]];
            e_m.fs = (pos == 0);
            if (msub <= m_bri) begin
                e_m.sel = ~(4'b0001 << md);
                e_m.led = {~m_dp[md], m_pat[6:0]};
            end else begin
                e_m.sel = 4'hF;
                e_m.led = 8'hFF;
            end
            pos = (pos + 1) % 64;
        end
        exp_q.push_back(e_m);
    end

    exp_t e_c;
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            e_c = exp_q.pop_front();
            total++;
            if (SEG_SELECT !== e_c.sel || LED_OUT !== e_c.led || FRAME_START !== e_c.fs) begin
                bad++;
                $display("FAIL scan @%0t: got sel=%b led=%h fs=%b, want sel=%b led=%h fs=%b",
                         $time, SEG_SELECT, LED_OUT, FRAME_START, e_c.sel, e_c.led, e_c.fs);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_in(input logic [3:0] d3, d2, d1, d0, dp, input logic ben, input logic [2:0] bri);
        DIGIT3 = d3; DIGIT2 = d2; DIGIT1 = d1; DIGIT0 = d0;
        DP_MASK = dp; BLANK_EN = ben; BRIGHTNESS = bri;
    endtask

    task automatic rand_in();
        DIGIT0 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        DIGIT1 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        DIGIT2 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        DIGIT3 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        DP_MASK    = 4'($urandom_range(0, 15));
        BLANK_EN   = 1'($urandom_range(0, 1));
        BRIGHTNESS = 3'($urandom_range(0, 7));
    endtask

    task automatic check_reset_state();
        total++;
        if (SEG_SELECT !== 4'b1111 || LED_OUT !== 8'hFF || FRAME_START !== 1'b0) begin
            bad++;
            $display("FAIL reset @%0t: got sel=%b led=%h fs=%b, want sel=1111 led=ff fs=0",
                     $time, SEG_SELECT, LED_OUT, FRAME_START);
        end
    endtask

    task automatic wait_frame_start(input int max_cycles, output int waited);
        bit seen;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < max_cycles) begin
            cyc(1);
            waited++;
            if (FRAME_START === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL timeout @%0t: no FRAME_START within %0d cycles after reset release",
                     $time, max_cycles);
        end
    endtask

    int waited_cyc;

    initial begin
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_in();
            cyc(1);
            check_reset_state();
        end

        set_in(4'hA, 4'h3, 4'h2, 4'h1, 4'b0000, 1'b0, 3'd7);
        RESET = 1'b1;
        cyc(128);

        set_in(4'hA, 4'h3, 4'h2, 4'h1, 4'b0001, 1'b0, 3'd1);
        cyc(64);

        cyc(40);
        DIGIT0 = 4'h8;
        cyc(24 + 128);

        set_in(4'h0, 4'h0, 4'h5, 4'h0, 4'b0100, 1'b1, 3'd7);
        cyc(128);

        cyc(35);
        RESET = 1'b0;
        cyc(1);
        check_reset_state();
        RESET = 1'b1;
        wait_frame_start(70, waited_cyc);
        if (waited_cyc < 70) cyc(70 - waited_cyc);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) rand_in();
            RESET = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            cyc(1);
        end
        RESET = 1'b1;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
